// File: rtl/enc_pkg.sv
// Shared types and constants for the encryptor transmit path.
package enc_pkg;

   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned FRAME_BITS = 10;

   localparam logic TX_IDLE_LEVEL  = 1'b1;
   localparam logic TX_START_LEVEL = 1'b0;

   // Serializer frame states
   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_e;

endpackage

// File: rtl/enc_byte_fifo.sv
// Byte FIFO buffering encrypted bytes ahead of the serial link.
// Ports:
//   clock, reset   - rising-edge clock, synchronous active-high reset
//   push_data/push - write request; ignored when full
//   pop            - read request; ignored when empty
//   head           - oldest stored byte (valid when !empty)
//   count          - number of stored bytes (0..DEPTH)
//   full, empty    - status flags derived from count
module enc_byte_fifo #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned BYTE_W = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [BYTE_W-1:0]       push_data,
   input  logic                    push,
   input  logic                    pop,
   output logic [BYTE_W-1:0]       head,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full,
   output logic                    empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [BYTE_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Storage array; only written on an accepted push so idle X data never lands
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/enc_tx_serializer.sv
// Framed serial transmitter for encrypted bytes: start bit, 8 data bits
// MSB first, stop bit, each held BIT_CYCLES clocks. Bytes are buffered in
// a DEPTH-entry FIFO; queued bytes go out back to back with no idle gap.
// Ports:
//   clock, reset        - rising-edge clock, synchronous active-high reset
//   in_data/in_valid    - byte offered by the encryptor
//   in_ready            - FIFO not full (from count only)
//   tx_bit              - registered serial line, idles high
//   tx_busy             - registered, high from START through STOP
//   fifo_count          - bytes currently buffered
//   frame_done          - one-cycle pulse after each frame's last STOP cycle
module enc_tx_serializer
   import enc_pkg::*;
#(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned BIT_CYCLES = 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [BYTE_W-1:0]       in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic                    tx_bit,
   output logic                    tx_busy,
   output logic [$clog2(DEPTH):0]  fifo_count,
   output logic                    frame_done
);

   localparam int unsigned CCW = $clog2(BIT_CYCLES) + 1;
   localparam logic [CCW-1:0] LAST_CYC = CCW'(BIT_CYCLES - 1);

   tx_state_e         state;
   logic [BYTE_W-1:0] shift;
   logic [2:0]        bit_idx;
   logic [CCW-1:0]    cyc_cnt;
   logic [BYTE_W-1:0] head;
   logic              full;
   logic              empty;
   logic              pop;
   logic              last_cyc;

   enc_byte_fifo #(
      .DEPTH  (DEPTH),
      .BYTE_W (BYTE_W)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push_data (in_data),
      .push      (in_valid),
      .pop       (pop),
      .head      (head),
      .count     (fifo_count),
      .full      (full),
      .empty     (empty)
   );

   assign in_ready = !full;
   assign last_cyc = (cyc_cnt == LAST_CYC);

   // Head is taken when idle, or at the end of STOP to chain frames
   assign pop = !empty && ((state == IDLE) || ((state == STOP) && last_cyc));

   // Frame FSM, shift register and registered line outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         shift      <= '0;
         bit_idx    <= '0;
         cyc_cnt    <= '0;
         tx_bit     <= TX_IDLE_LEVEL;
         tx_busy    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               tx_bit <= TX_IDLE_LEVEL;
               if (pop) begin
                  state   <= START;
                  shift   <= head;
                  cyc_cnt <= '0;
                  tx_bit  <= TX_START_LEVEL;
                  tx_busy <= 1'b1;
               end
            end
            START: begin
               if (last_cyc) begin
                  // MSB goes on the line now; shift so the next bit sits in [7]
                  state   <= DATA;
                  bit_idx <= 3'd7;
                  cyc_cnt <= '0;
                  tx_bit  <= shift[BYTE_W-1];
                  shift   <= {shift[BYTE_W-2:0], 1'b0};
               end else begin
                  cyc_cnt <= cyc_cnt + CCW'(1);
               end
            end
            DATA: begin
               if (last_cyc) begin
                  cyc_cnt <= '0;
                  if (bit_idx == 3'd0) begin
                     state  <= STOP;
                     tx_bit <= TX_IDLE_LEVEL;
                  end else begin
                     bit_idx <= bit_idx - 3'd1;
                     tx_bit  <= shift[BYTE_W-1];
                     shift   <= {shift[BYTE_W-2:0], 1'b0};
                  end
               end else begin
                  cyc_cnt <= cyc_cnt + CCW'(1);
               end
            end
            STOP: begin
               if (last_cyc) begin
                  cyc_cnt    <= '0;
                  frame_done <= 1'b1;
                  if (pop) begin
                     state  <= START;
                     shift  <= head;
                     tx_bit <= TX_START_LEVEL;
                  end else begin
                     state   <= IDLE;
                     tx_bit  <= TX_IDLE_LEVEL;
                     tx_busy <= 1'b0;
                  end
               end else begin
                  cyc_cnt <= cyc_cnt + CCW'(1);
               end
            end
            default: begin
               state   <= IDLE;
               tx_bit  <= TX_IDLE_LEVEL;
               tx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_enc_tx_serializer.sv
// Directed bench for enc_tx_serializer: table of single-byte frames plus
// hand-written back-to-back, fill, stretched-bit and reset-abort sequences.
module tb_enc_tx_serializer;

   logic       clock;
   logic       reset;

   // Instance with BIT_CYCLES=1
   logic [7:0] in_data1;
   logic       in_valid1;
   logic       in_ready1;
   logic       tx1;
   logic       busy1;
   logic [2:0] cnt1;
   logic       done1;

   // Instance with BIT_CYCLES=3
   logic [7:0] in_data3;
   logic       in_valid3;
   logic       in_ready3;
   logic       tx3;
   logic       busy3;
   logic [2:0] cnt3;
   logic       done3;

   int tests;
   int fails;

   typedef struct {
      logic [7:0] data;
      logic [9:0] bits;   // line levels in send order, [9] first
   } vec_t;

   vec_t vecs [6];

   enc_tx_serializer #(.DEPTH(4), .BIT_CYCLES(1)) dut (
      .clock      (clock),
      .reset      (reset),
      .in_data    (in_data1),
      .in_valid   (in_valid1),
      .in_ready   (in_ready1),
      .tx_bit     (tx1),
      .tx_busy    (busy1),
      .fifo_count (cnt1),
      .frame_done (done1)
   );

   enc_tx_serializer #(.DEPTH(4), .BIT_CYCLES(3)) dut3 (
      .clock      (clock),
      .reset      (reset),
      .in_data    (in_data3),
      .in_valid   (in_valid3),
      .in_ready   (in_ready3),
      .tx_bit     (tx3),
      .tx_busy    (busy3),
      .fifo_count (cnt3),
      .frame_done (done3)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [9:0] frame_bits(input logic [7:0] d);
      return {1'b0, d, 1'b1};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Called at a negedge; push lands on the following posedge
   task automatic push1(input bit sel, input logic [7:0] d);
      if (sel) begin in_valid3 = 1'b1; in_data3 = d; end
      else     begin in_valid1 = 1'b1; in_data1 = d; end
      @(negedge clock);
      if (sel) begin in_valid3 = 1'b0; in_data3 = 'x; end
      else     begin in_valid1 = 1'b0; in_data1 = 'x; end
   endtask

   // Starts at the negedge of the first START cycle; ends one negedge past STOP
   task automatic capture(input bit sel, input logic [9:0] bits, input int b, input string nm);
      for (int j = 0; j < 10; j++) begin
         for (int c = 0; c < b; c++) begin
            chk($sformatf("%s bit%0d cyc%0d", nm, j, c), sel ? tx3 : tx1, bits[9-j]);
            chk($sformatf("%s busy%0d", nm, j), sel ? busy3 : busy1, 1);
            if (j != 0 || c != 0)
               chk($sformatf("%s done_low%0d", nm, j), sel ? done3 : done1, 0);
            @(negedge clock);
         end
      end
   endtask

   task automatic post_idle(input bit sel, input string nm);
      chk({nm, " frame_done"}, sel ? done3 : done1, 1);
      chk({nm, " busy_after"}, sel ? busy3 : busy1, 0);
      chk({nm, " tx_idle"},    sel ? tx3 : tx1, 1);
      @(negedge clock);
      chk({nm, " done_one_cycle"}, sel ? done3 : done1, 0);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      vecs[0] = '{8'hA5, 10'b0101001011};
      vecs[1] = '{8'h3C, 10'b0001111001};
      vecs[2] = '{8'hF0, 10'b0111100001};
      vecs[3] = '{8'h00, 10'b0000000001};
      vecs[4] = '{8'hFF, 10'b0111111111};
      vecs[5] = '{8'h80, 10'b0100000001};

      reset = 1'b1;
      in_valid1 = 1'b0; in_data1 = 'x;
      in_valid3 = 1'b0; in_data3 = 'x;
      repeat (2) @(negedge clock);
      reset = 1'b0;

      // Reset state
      chk("rst tx",       tx1, 1);
      chk("rst busy",     busy1, 0);
      chk("rst count",    cnt1, 0);
      chk("rst ready",    in_ready1, 1);
      chk("rst done",     done1, 0);
      chk("rst tx3",      tx3, 1);
      chk("rst count3",   cnt3, 0);
      repeat (3) @(negedge clock);
      chk("idle x-data count", cnt1, 0);
      chk("idle x-data tx",    tx1, 1);

      // Single-byte frames with latency check
      for (int v = 0; v < 6; v++) begin
         push1(1'b0, vecs[v].data);
         chk($sformatf("v%0d pushed count", v), cnt1, 1);
         chk($sformatf("v%0d pre-pop tx", v), tx1, 1);
         chk($sformatf("v%0d pre-pop busy", v), busy1, 0);
         @(negedge clock);
         chk($sformatf("v%0d popped count", v), cnt1, 0);
         capture(1'b0, vecs[v].bits, 1, $sformatf("v%0d", v));
         post_idle(1'b0, $sformatf("v%0d", v));
         @(negedge clock);
      end

      // Back-to-back 0x3C then 0xF0
      in_valid1 = 1'b1; in_data1 = 8'h3C;
      @(negedge clock);
      in_data1 = 8'hF0;
      @(negedge clock);
      in_valid1 = 1'b0; in_data1 = 'x;
      chk("b2b count", cnt1, 1);
      capture(1'b0, 10'b0001111001, 1, "b2b 3C");
      chk("b2b first done", done1, 1);
      capture(1'b0, 10'b0111100001, 1, "b2b F0");
      post_idle(1'b0, "b2b");
      @(negedge clock);

      // Push/pop coincide while FIFO holds 2 bytes
      in_valid1 = 1'b1; in_data1 = 8'h11;
      @(negedge clock);
      in_data1 = 8'h22;
      @(negedge clock);
      in_data1 = 8'h33;
      @(negedge clock);
      in_valid1 = 1'b0; in_data1 = 'x;
      chk("pp holds2", cnt1, 2);
      repeat (8) @(negedge clock);
      chk("pp stop bit", tx1, 1);
      chk("pp stop count", cnt1, 2);
      in_valid1 = 1'b1; in_data1 = 8'h44;
      @(negedge clock);
      in_valid1 = 1'b0; in_data1 = 'x;
      chk("pp count unchanged", cnt1, 2);
      chk("pp frame_done", done1, 1);
      capture(1'b0, frame_bits(8'h22), 1, "pp 22");
      capture(1'b0, frame_bits(8'h33), 1, "pp 33");
      capture(1'b0, frame_bits(8'h44), 1, "pp 44");
      post_idle(1'b0, "pp");
      @(negedge clock);

      // Hold in_valid with 0x01..0x06, FIFO fills and drains in order
      fork
         begin : producer
            int sent;
            int guard;
            bit rdy;
            bit saw_full;
            sent = 0; guard = 0; saw_full = 0;
            while (sent < 6 && guard < 200) begin
               in_valid1 = 1'b1;
               in_data1  = 8'(sent + 1);
               rdy = in_ready1;
               chk("fill ready rule", in_ready1, (cnt1 != 3'd4) ? 1 : 0);
               if (cnt1 == 3'd4) saw_full = 1'b1;
               @(negedge clock);
               if (rdy) sent++;
               guard++;
            end
            in_valid1 = 1'b0; in_data1 = 'x;
            chk("fill all sent", sent, 6);
            chk("fill reached full", saw_full, 1);
         end
         begin : consumer
            int w;
            w = 0;
            while (!busy1 && w < 20) begin
               @(negedge clock);
               w++;
            end
            chk("fill start seen", busy1, 1);
            for (int f = 0; f < 6; f++)
               capture(1'b0, frame_bits(8'(f + 1)), 1, $sformatf("fill f%0d", f));
            post_idle(1'b0, "fill");
            chk("fill empty", cnt1, 0);
         end
      join
      @(negedge clock);

      // BIT_CYCLES=3 stretched frame of 0x80
      push1(1'b1, 8'h80);
      chk("bc3 pre-pop tx", tx3, 1);
      @(negedge clock);
      chk("bc3 popped count", cnt3, 0);
      capture(1'b1, 10'b0100000001, 3, "bc3");
      post_idle(1'b1, "bc3");
      @(negedge clock);

      // Reset during DATA of 0xFF with two bytes queued
      in_valid1 = 1'b1; in_data1 = 8'hFF;
      @(negedge clock);
      in_data1 = 8'h11;
      @(negedge clock);
      in_data1 = 8'h22;
      @(negedge clock);
      in_valid1 = 1'b0; in_data1 = 'x;
      repeat (2) @(negedge clock);
      chk("abort mid busy", busy1, 1);
      chk("abort mid count", cnt1, 2);
      chk("abort mid data bit", tx1, 1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("abort tx", tx1, 1);
      chk("abort count", cnt1, 0);
      chk("abort busy", busy1, 0);
      chk("abort ready", in_ready1, 1);
      begin
         int bad;
         bad = 0;
         for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (busy1 !== 1'b0 || tx1 !== 1'b1 || done1 !== 1'b0 || cnt1 !== 3'd0) bad++;
         end
         chk("abort stays idle", bad, 0);
      end
      push1(1'b0, 8'h5A);
      @(negedge clock);
      capture(1'b0, frame_bits(8'h5A), 1, "recover 5A");
      post_idle(1'b0, "recover");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
